// File: rtl/d_jb_pkg.sv
// Shared encodings for the decode-stage jump/branch controller and its BHT.
package d_jb_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;

  typedef enum logic [2:0] {
    BOP_NONE = 3'b000,
    BOP_BEQ  = 3'b001,
    BOP_BNE  = 3'b010,
    BOP_BLEZ = 3'b011,
    BOP_BGTZ = 3'b100,
    BOP_BLTZ = 3'b101,
    BOP_BGEZ = 3'b110
  } bop_t;

  typedef enum logic [1:0] {
    JMP_SEQ   = 2'b00,
    JMP_J     = 2'b01,
    JMP_JR    = 2'b10,
    JMP_OTHER = 2'b11
  } jump_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    FIX  = 2'b10
  } state_t;

  localparam logic [1:0] RDR_NONE   = 2'b00;
  localparam logic [1:0] RDR_TARGET = 2'b01;
  localparam logic [1:0] RDR_PC4    = 2'b10;

endpackage

// File: rtl/d_jb_predict_ctrl_bht.sv
// Branch history table: saturating counters, one combinational read port and
// one clocked update port. Same-cycle read of the updated index sees the old value.
module d_bht #(
  parameter int IDX_W = 6,
  parameter int CTR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0] o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int              N        = 2**IDX_W;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [CTR_W-1:0] r_ctr [N];
  logic [CTR_W-1:0] w_ctr_upd;

  assign o_rd_ctr = r_ctr[i_rd_idx];

  always_comb begin
    w_ctr_upd = r_ctr[i_wr_idx];
    if (i_wr_taken) begin
      if (w_ctr_upd != CTR_MAX) w_ctr_upd = w_ctr_upd + CTR_ONE;
    end else begin
      if (w_ctr_upd != '0) w_ctr_upd = w_ctr_upd - CTR_ONE;
    end
  end

  // Every entry starts weakly not-taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) r_ctr[i] <= CTR_ONE;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= w_ctr_upd;
    end
  end

endmodule

// File: rtl/d_jb_predict_ctrl.sv
// Decode-stage jump/branch controller: decode, BHT prediction and a
// single-outstanding-branch tracker producing stall, flush and redirect.
module d_jb_predict_ctrl
  import d_jb_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int IDX_W     = 6,
  parameter int CTR_W     = 2,
  parameter int PRED_MODE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_hold,
  input  logic [5:0]      i_instru,
  input  logic [5:0]      i_func,
  input  logic            i_rt,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_res_valid,
  input  logic            i_res_taken,
  output logic [1:0]      o_jump,
  output logic [2:0]      o_bop,
  output logic            o_aluPC4,
  output logic            o_ifstall,
  output logic            o_pred_taken,
  output logic            o_flush,
  output logic [1:0]      o_redirect,
  output logic            o_busy
);

  localparam logic MODE_PRED = (PRED_MODE != 0);

  bop_t             w_bop;
  jump_t            w_jump;
  logic             w_alupc4;
  logic             w_is_br;
  logic [IDX_W-1:0] w_idx;
  logic [CTR_W-1:0] w_rd_ctr;
  logic             w_pred;
  logic             w_capture;
  logic             w_resolve;
  logic             w_mispred;
  logic             w_fix_flush;
  logic [1:0]       w_fix_redirect;
  logic             w_unused_pc;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_pred;
  logic             r_flush;
  logic [1:0]       r_redirect;

  assign w_idx       = i_pc[IDX_W+1:2];
  assign w_unused_pc = ^{i_pc[PC_W-1:IDX_W+2], i_pc[1:0]};

  always_comb begin
    w_bop    = BOP_NONE;
    w_jump   = JMP_SEQ;
    w_alupc4 = 1'b0;
    if (i_valid) begin
      case (i_instru)
        OP_SPECIAL: if (i_func == FN_JR) w_jump = JMP_JR;
        OP_REGIMM:  w_bop = i_rt ? BOP_BGEZ : BOP_BLTZ;
        OP_J:       w_jump = JMP_J;
        OP_JAL:     begin w_jump = JMP_J; w_alupc4 = 1'b1; end
        OP_BEQ:     w_bop = BOP_BEQ;
        OP_BNE:     w_bop = BOP_BNE;
        OP_BLEZ:    w_bop = BOP_BLEZ;
        OP_BGTZ:    w_bop = BOP_BGTZ;
        default:    w_jump = JMP_OTHER;
      endcase
    end
  end

  assign w_is_br  = (w_bop != BOP_NONE);
  assign o_jump   = w_jump;
  assign o_bop    = w_bop;
  assign o_aluPC4 = w_alupc4;

  d_bht #(.IDX_W(IDX_W), .CTR_W(CTR_W)) u_bht (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_idx   (w_idx),
    .o_rd_ctr   (w_rd_ctr),
    .i_wr_en    (w_resolve),
    .i_wr_idx   (r_idx),
    .i_wr_taken (i_res_taken)
  );

  assign w_pred    = MODE_PRED & w_rd_ctr[CTR_W-1];
  assign w_resolve = (r_state == PEND) && i_res_valid;
  // Legacy mode predicts not-taken implicitly, so any taken outcome needs a redirect.
  assign w_mispred = MODE_PRED ? (i_res_taken != r_pred) : i_res_taken;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_pred     <= 1'b0;
      r_flush    <= 1'b0;
      r_redirect <= RDR_NONE;
    end else begin
      r_state    <= w_state_next;
      r_flush    <= w_fix_flush;
      r_redirect <= w_fix_redirect;
      if (w_capture) begin
        r_idx  <= w_idx;
        r_pred <= w_pred;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: if (w_is_br && !i_hold) begin
        w_capture    = 1'b1;
        w_state_next = PEND;
      end
      PEND: if (i_res_valid) w_state_next = w_mispred ? FIX : IDLE;
      FIX:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ifstall      = 1'b0;
    o_pred_taken   = 1'b0;
    w_fix_flush    = 1'b0;
    w_fix_redirect = RDR_NONE;
    if (r_state == IDLE) begin
      o_ifstall    = w_is_br && !MODE_PRED;
      o_pred_taken = w_is_br && w_pred;
    end else begin
      o_ifstall = w_is_br;
    end
    if (w_resolve && w_mispred) begin
      w_fix_flush    = MODE_PRED;
      w_fix_redirect = (MODE_PRED && !i_res_taken) ? RDR_PC4 : RDR_TARGET;
    end
  end

  assign o_flush    = r_flush;
  assign o_redirect = r_redirect;
  assign o_busy     = (r_state != IDLE);

endmodule

// File: doc/d_jb_predict_ctrl.md
Name: d_jb_predict_ctrl

Overview:
Next-generation decode-stage jump/branch controller for the MIPS pipeline.
- Decodes j/jal/jr and the six conditional branches (beq, bne, blez, bgtz, bltz, bgez) into jump-select and branch-op codes.
- Adds a parametrised branch history table (BHT) of saturating counters and a single-outstanding-branch tracking FSM.
- In predict mode, fetch continues speculatively past branches; mispredicts produce a one-cycle flush/redirect. In legacy mode it stalls fetch on every branch.

Parameters:
PC_W, 32, program counter width
IDX_W, 6, BHT index width; BHT has 2**IDX_W entries, indexed by i_pc[IDX_W+1:2]
CTR_W, 2, counter width per BHT entry (>=1); predict taken = counter MSB
PRED_MODE, 1, 0 = legacy stall-on-branch, 1 = BHT speculation

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  D-stage instruction valid
i_hold  in  1  D stage held by downstream stall; no capture while high
i_instru  in  6  opcode
i_func  in  6  function code
i_rt  in  1  instruction bit 16 (bltz/bgez select)
i_pc  in  PC_W  PC of D-stage instruction
i_res_valid  in  1  EX reports resolution of outstanding branch
i_res_taken  in  1  actual branch outcome
o_jump  out  2  00 branch/sequential, 01 j/jal, 10 jr, 11 other
o_bop  out  3  001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 000 none
o_aluPC4  out  1  jal: write PC+4 via ALU
o_ifstall  out  1  stall fetch
o_pred_taken  out  1  prediction for branch in D
o_flush  out  1  squash wrong-path IF/D instructions
o_redirect  out  2  00 none, 01 fetch branch target, 10 fetch branch PC+4
o_busy  out  1  branch outstanding (state != IDLE)

Behaviour:
- Decode (combinational), gated by i_valid. When !i_valid: all decode outputs 0, o_jump = 00.
  - Opcode 000000 with func 001000 → jr.
  - Opcode 000000 otherwise → o_jump = 00.
  - Opcode 000001 → bltz if i_rt = 0, else bgez.
  - Unlisted opcodes → o_jump = 11.
- Reset: state IDLE, every BHT counter = 1 (weakly not-taken), captured index/prediction = 0. o_flush, o_redirect, o_busy = 0. Asynchronous reset mid-operation abandons the outstanding branch.
- FSM states: IDLE, PEND, FIX.
- IDLE, decoded branch, i_valid, !i_hold:
  - Capture index and prediction (counter MSB in mode 1, 0 in mode 0).
  - Next state PEND.
  - o_pred_taken = prediction (0 in mode 0).
  - o_ifstall = 1 in mode 0, 0 in mode 1.
- PEND:
  - o_busy = 1. Any decoded branch in D → o_ifstall = 1, not captured (one outstanding branch only).
  - Jumps are not stalled.
  - On i_res_valid:
    - Update captured BHT entry: +1 if taken, -1 if not, saturating at 0 and 2**CTR_W-1.
    - Mode 1: mispredict → FIX; correct → IDLE.
    - Mode 0: taken → FIX; not taken → IDLE.
- FIX (exactly one cycle, then IDLE), o_busy = 1:
  - Mode 1: o_flush = 1; o_redirect = 01 if actual outcome taken, else 10.
  - Mode 0: o_flush = 0, o_redirect = 01.
  - A branch in D is not captured and o_ifstall = 1.
- o_flush/o_redirect are registered: asserted only in the cycle after resolution, 0 otherwise.
- i_res_valid in IDLE or FIX: ignored, no BHT update.
- Resolution and a new D-stage branch in the same PEND cycle: the new branch stalls; it is captured when the FSM returns to IDLE.
- BHT read is combinational from i_pc. The write (update) happens at the clock edge. A read of the same index in the update cycle returns the old value.

Decomposition:
- Package d_jb_pkg holds:
  - opcode/func constants;
  - bop_t and jump_t enums with the encodings above;
  - state_t {IDLE, PEND, FIX}.
- Sub-module d_bht (parameters IDX_W, CTR_W):
  - counter array with async reset;
  - one combinational read port;
  - one saturating-update write port.

Test Plan:
- Reset, then opcode 000010 with i_valid → o_jump = 01, o_bop = 000, o_ifstall = 0; opcode 000011 → additionally o_aluPC4 = 1; 000000/001000 → o_jump = 10.
- Mode 1, beq at pc 0x40, fresh BHT → o_pred_taken = 0, o_busy next cycle. Resolve taken → one cycle later o_flush = 1, o_redirect = 01. Entry 16 counter becomes 2.
- Same beq resolved taken three times → counter saturates at 3, o_pred_taken = 1. Resolve not taken → o_flush = 1, o_redirect = 10, counter = 2.
- Mode 0, bgez (opcode 000001, i_rt = 1) → o_bop = 110, o_ifstall = 1. Resolve taken → o_redirect = 01, o_flush = 0.
- Second bne in D while PEND → o_ifstall = 1 until IDLE, then captured. i_res_valid pulsed in IDLE → no BHT change.
- Assert i_rst_n low during PEND → immediate IDLE, o_busy = 0, all counters = 1.
